// File: rtl/transient_detector.sv
// transient_detector
// Windowed-energy onset detector. After arm_in, sums |mic_in| over
// WINDOW_SIZE-sample windows (one sample per step_in strobe) and flags an
// onset when a window's energy exceeds the previous window and 1.5x the
// window before that. Reports the onset sample index, or a timeout after
// MAX_SAMPLES samples without an onset.
//
// Ports:
//   clk_in            system clock
//   rst_n_in          asynchronous active-low reset
//   step_in           one-cycle sample strobe
//   arm_in            one-cycle pulse, starts/restarts a run
//   mic_in            signed 8-bit sample, valid with step_in
//   busy_out          high while a run is active
//   onset_out         one-cycle pulse, onset detected
//   onset_sample      sample index of the last onset (held)
//   timeout_out       one-cycle pulse, run ended without onset
//   window_energy_out energy of the most recently completed window
//   window_valid_out  one-cycle pulse when window_energy_out updates
module transient_detector #(
  parameter int unsigned WINDOW_SIZE = 16,
  parameter int unsigned SUM_W       = 20,
  parameter int unsigned MAX_SAMPLES = 512
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             step_in,
  input  logic             arm_in,
  input  logic [7:0]       mic_in,
  output logic             busy_out,
  output logic             onset_out,
  output logic [11:0]      onset_sample,
  output logic             timeout_out,
  output logic [SUM_W-1:0] window_energy_out,
  output logic             window_valid_out
);

  localparam int unsigned IX_W  = $clog2(WINDOW_SIZE);
  localparam int unsigned CNT_W = 12;
  localparam int unsigned EXT_W = SUM_W + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [SUM_W-1:0]  cur_sum_q, cur_sum_d;
  logic [SUM_W-1:0]  prev_sum_q, prev_sum_d;
  logic [SUM_W-1:0]  pprev_sum_q, pprev_sum_d;
  logic [IX_W-1:0]   window_ix_q, window_ix_d;
  logic [CNT_W-1:0]  sample_count_q, sample_count_d;
  logic              onset_q, onset_d;
  logic [CNT_W-1:0]  onset_sample_q, onset_sample_d;
  logic              timeout_q, timeout_d;
  logic [SUM_W-1:0]  energy_q, energy_d;
  logic              valid_q, valid_d;

  logic [7:0]        mag_c;
  logic [EXT_W-1:0]  sum_ext_c;
  logic [SUM_W-1:0]  sum_sat_c;
  logic [EXT_W-1:0]  thresh_c;
  logic              onset_hit_c;
  logic              window_end_c;
  logic [CNT_W-1:0]  count_inc_c;

  // Magnitude, saturating accumulate and onset comparison (one extra bit of headroom)
  always_comb begin
    mag_c        = mic_in[7] ? (~mic_in + 8'd1) : mic_in;
    sum_ext_c    = EXT_W'(cur_sum_q) + EXT_W'(mag_c);
    sum_sat_c    = sum_ext_c[SUM_W] ? {SUM_W{1'b1}} : sum_ext_c[SUM_W-1:0];
    thresh_c     = EXT_W'(pprev_sum_q) + EXT_W'(pprev_sum_q >> 1);
    onset_hit_c  = (sum_sat_c > prev_sum_q) && (EXT_W'(sum_sat_c) > thresh_c);
    window_end_c = (window_ix_q == IX_W'(WINDOW_SIZE - 1));
    count_inc_c  = sample_count_q + CNT_W'(1);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    cur_sum_d      = cur_sum_q;
    prev_sum_d     = prev_sum_q;
    pprev_sum_d    = pprev_sum_q;
    window_ix_d    = window_ix_q;
    sample_count_d = sample_count_q;
    onset_d        = 1'b0;
    onset_sample_d = onset_sample_q;
    timeout_d      = 1'b0;
    energy_d       = energy_q;
    valid_d        = 1'b0;

    if (arm_in) begin
      // All-ones history blocks detection until two real windows exist
      state_d        = RUN;
      cur_sum_d      = '0;
      window_ix_d    = '0;
      sample_count_d = '0;
      prev_sum_d     = {SUM_W{1'b1}};
      pprev_sum_d    = {SUM_W{1'b1}};
    end else if (state_q == RUN && step_in) begin
      sample_count_d = count_inc_c;
      if (!window_end_c) begin
        cur_sum_d   = sum_sat_c;
        window_ix_d = window_ix_q + IX_W'(1);
      end else begin
        energy_d    = sum_sat_c;
        valid_d     = 1'b1;
        pprev_sum_d = prev_sum_q;
        prev_sum_d  = sum_sat_c;
        cur_sum_d   = '0;
        window_ix_d = '0;
      end
      if (window_end_c && onset_hit_c) begin
        onset_d        = 1'b1;
        onset_sample_d = count_inc_c;
        state_d        = IDLE;
      end else if (count_inc_c == CNT_W'(MAX_SAMPLES)) begin
        timeout_d = 1'b1;
        state_d   = IDLE;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= IDLE;
      cur_sum_q      <= '0;
      prev_sum_q     <= '0;
      pprev_sum_q    <= '0;
      window_ix_q    <= '0;
      sample_count_q <= '0;
      onset_q        <= 1'b0;
      onset_sample_q <= '0;
      timeout_q      <= 1'b0;
      energy_q       <= '0;
      valid_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_sum_q      <= cur_sum_d;
      prev_sum_q     <= prev_sum_d;
      pprev_sum_q    <= pprev_sum_d;
      window_ix_q    <= window_ix_d;
      sample_count_q <= sample_count_d;
      onset_q        <= onset_d;
      onset_sample_q <= onset_sample_d;
      timeout_q      <= timeout_d;
      energy_q       <= energy_d;
      valid_q        <= valid_d;
    end
  end

  assign busy_out          = (state_q == RUN);
  assign onset_out         = onset_q;
  assign onset_sample      = onset_sample_q;
  assign timeout_out       = timeout_q;
  assign window_energy_out = energy_q;
  assign window_valid_out  = valid_q;

endmodule

// File: tb/tb_transient_detector.sv
// Scoreboard bench for transient_detector (WINDOW_SIZE=4, MAX_SAMPLES=32).
// Stimulus pushes expected window/onset/timeout events; a forked monitor
// pops and compares them whenever the DUT pulses an output.
module tb_transient_detector;

  localparam int unsigned WS = 4;
  localparam int unsigned SW = 20;
  localparam int unsigned MS = 32;

  localparam int K_WIN = 0;
  localparam int K_ONSET = 1;
  localparam int K_TMO = 2;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          step_in;
  logic          arm_in;
  logic [7:0]    mic_in;
  logic          busy_out;
  logic          onset_out;
  logic [11:0]   onset_sample;
  logic          timeout_out;
  logic [SW-1:0] window_energy_out;
  logic          window_valid_out;

  typedef struct {
    int          kind;
    int unsigned value;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  transient_detector #(
    .WINDOW_SIZE(WS),
    .SUM_W      (SW),
    .MAX_SAMPLES(MS)
  ) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .step_in          (step_in),
    .arm_in           (arm_in),
    .mic_in           (mic_in),
    .busy_out         (busy_out),
    .onset_out        (onset_out),
    .onset_sample     (onset_sample),
    .timeout_out      (timeout_out),
    .window_energy_out(window_energy_out),
    .window_valid_out (window_valid_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input int kind, input int unsigned value);
    exp_t e;
    e.kind  = kind;
    e.value = value;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input int kind, input longint unsigned act, input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected event kind %0d value %0d, expected none (t=%0t)",
               name, kind, act, $time);
    end else begin
      e = sb_q.pop_front();
      check({name, "_kind"}, longint'(kind), longint'(e.kind));
      check(name, act, longint'(e.value));
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk_in);
      if (window_valid_out) pop_check(K_WIN, window_energy_out, "window_energy");
      if (onset_out) begin
        pop_check(K_ONSET, onset_sample, "onset_sample");
        check("busy_at_onset", busy_out, 0);
      end
      if (timeout_out) begin
        pop_check(K_TMO, onset_sample, "timeout_held_onset_sample");
        check("busy_at_timeout", busy_out, 0);
      end
    end
  endtask

  // Arm pulse; optionally with a simultaneous strobe that must be ignored
  task automatic arm(input bit step_too);
    @(negedge clk_in);
    arm_in  = 1'b1;
    step_in = step_too;
    mic_in  = 8'd100;
    @(negedge clk_in);
    arm_in  = 1'b0;
    step_in = 1'b0;
    check("busy_after_arm", busy_out, 1);
  endtask

  task automatic samples(input logic [7:0] v, input int n, input bit b2b);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      step_in = 1'b1;
      mic_in  = v;
      if (!b2b) begin
        @(negedge clk_in);
        step_in = 1'b0;
      end
    end
    @(negedge clk_in);
    step_in = 1'b0;
  endtask

  task automatic scenario_onset12();
    expect_ev(K_WIN, 8);
    expect_ev(K_WIN, 8);
    expect_ev(K_WIN, 400);
    expect_ev(K_ONSET, 12);
    samples(8'd2, 8, 1'b1);
    samples(8'd100, 4, 1'b1);
    @(negedge clk_in);
    check("busy_after_onset", busy_out, 0);
  endtask

  initial begin
    rst_n_in = 1'b0;
    step_in  = 1'b0;
    arm_in   = 1'b0;
    mic_in   = 8'd0;
    #1;
    check("reset_busy", busy_out, 0);
    check("reset_onset", onset_out, 0);
    check("reset_onset_sample", onset_sample, 0);
    check("reset_timeout", timeout_out, 0);
    check("reset_energy", window_energy_out, 0);
    check("reset_valid", window_valid_out, 0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    fork
      monitor_loop();
    join_none

    // 1: onset at sample 12
    arm(1'b0);
    scenario_onset12();

    // 2: detection blocked until two windows, then 508 vs 400/600 and 508 vs 508
    arm(1'b0);
    expect_ev(K_WIN, 0);
    expect_ev(K_WIN, 400);
    expect_ev(K_WIN, 400);
    expect_ev(K_WIN, 508);
    expect_ev(K_WIN, 508);
    samples(8'd0, 4, 1'b0);
    samples(8'd100, 8, 1'b0);
    samples(8'd127, 8, 1'b0);
    check("busy_no_onset", busy_out, 1);

    // 3: timeout after 32 zero samples, onset_sample held at 12
    arm(1'b0);
    for (int i = 0; i < 8; i++) expect_ev(K_WIN, 0);
    expect_ev(K_TMO, 12);
    samples(8'd0, 32, 1'b1);
    check("busy_after_timeout", busy_out, 0);

    // strobes while idle are ignored
    samples(8'd50, 4, 1'b0);

    // 4: most-negative sample magnitude is 128
    arm(1'b0);
    expect_ev(K_WIN, 512);
    samples(8'h80, 4, 1'b0);

    // 5: re-arm mid-run (strobe in the arm cycle ignored)
    arm(1'b0);
    expect_ev(K_WIN, 400);
    samples(8'd100, 6, 1'b1);
    arm(1'b1);
    scenario_onset12();

    // 6: asynchronous reset mid-run
    arm(1'b0);
    expect_ev(K_WIN, 200);
    samples(8'd50, 5, 1'b1);
    @(posedge clk_in);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("midrun_reset_busy", busy_out, 0);
    check("midrun_reset_onset_sample", onset_sample, 0);
    check("midrun_reset_energy", window_energy_out, 0);
    check("midrun_reset_valid", window_valid_out, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    samples(8'd100, 8, 1'b1);
    check("busy_after_reset_steps", busy_out, 0);

    // recovery after reset
    arm(1'b0);
    scenario_onset12();

    repeat (3) @(negedge clk_in);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
